// File: rtl/rf_writeback_arbiter.sv
// Two-requester writeback arbiter in front of the single register-file write port.
// Latency: write accepted at edge E0 drives RF_Ld after E1; contention adds at most one cycle.
// Backpressure: X_Ready = !full_X || grant_X, so each side streams 1/cycle when uncontended.
module rf_writeback_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          DROP_R0 = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [4:0]        A_Select,
  input  logic [DATA_W-1:0] A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [4:0]        B_Select,
  input  logic [DATA_W-1:0] B_Data,
  output logic              RF_Ld,
  output logic [4:0]        RF_Select,
  output logic [DATA_W-1:0] RF_Data,
  output logic [31:0]       Pending_Mask,
  output logic              Busy
);

  // Relative age of the two buffers; only meaningful while both are full.
  typedef enum logic [1:0] {
    AGE_EQ    = 2'd0,
    AGE_A_OLD = 2'd1,
    AGE_B_OLD = 2'd2
  } age_t;

  logic              full_a_q, full_a_d;
  logic [4:0]        sel_a_q, sel_a_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic              full_b_q, full_b_d;
  logic [4:0]        sel_b_q, sel_b_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  age_t              age_q, age_d;
  logic              rr_q, rr_d;          // 0: A preferred on next contention, 1: B preferred
  logic              rf_ld_q, rf_ld_d;
  logic [4:0]        rf_sel_q, rf_sel_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic grant_a, grant_b, contend_rr;
  logic load_a, load_b;

  // Grant decision from buffer state at the start of the cycle.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    contend_rr = 1'b0;
    if (full_a_q && full_b_q) begin
      if (sel_a_q == sel_b_q) begin
        // Same destination: older write first, ties go to A to keep program order.
        grant_a = (age_q != AGE_B_OLD);
      end else begin
        contend_rr = 1'b1;
        grant_a    = (rr_q == 1'b0);
      end
      grant_b = !grant_a;
    end else begin
      grant_a = full_a_q;
      grant_b = full_b_q;
    end
  end

  assign A_Ready = !full_a_q || grant_a;
  assign B_Ready = !full_b_q || grant_b;
  assign load_a  = A_Valid && A_Ready;
  assign load_b  = B_Valid && B_Ready;

  // Next buffer contents, age, round-robin pointer and write-port values.
  always_comb begin
    full_a_d  = full_a_q;
    sel_a_d   = sel_a_q;
    data_a_d  = data_a_q;
    full_b_d  = full_b_q;
    sel_b_d   = sel_b_q;
    data_b_d  = data_b_q;
    age_d     = age_q;
    rr_d      = rr_q;
    rf_ld_d   = 1'b0;
    rf_sel_d  = rf_sel_q;
    rf_data_d = rf_data_q;

    if (grant_a) full_a_d = 1'b0;
    if (grant_b) full_b_d = 1'b0;
    // A load on the issuing edge replaces the departing entry, keeping the buffer full.
    if (load_a) begin
      full_a_d = 1'b1;
      sel_a_d  = A_Select;
      data_a_d = A_Data;
    end
    if (load_b) begin
      full_b_d = 1'b1;
      sel_b_d  = B_Select;
      data_b_d = B_Data;
    end

    if (load_a && load_b)                          age_d = AGE_EQ;
    else if (load_a && full_b_q && !grant_b)       age_d = AGE_B_OLD;
    else if (load_b && full_a_q && !grant_a)       age_d = AGE_A_OLD;

    if (contend_rr) rr_d = grant_a;

    if (grant_a) begin
      rf_sel_d  = sel_a_q;
      rf_data_d = data_a_q;
      rf_ld_d   = !(DROP_R0 && (sel_a_q == 5'd0));
    end else if (grant_b) begin
      rf_sel_d  = sel_b_q;
      rf_data_d = data_b_q;
      rf_ld_d   = !(DROP_R0 && (sel_b_q == 5'd0));
    end
  end

  // State registers; reset discards any buffered writes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      full_a_q  <= 1'b0;
      sel_a_q   <= 5'd0;
      data_a_q  <= '0;
      full_b_q  <= 1'b0;
      sel_b_q   <= 5'd0;
      data_b_q  <= '0;
      age_q     <= AGE_EQ;
      rr_q      <= 1'b0;
      rf_ld_q   <= 1'b0;
      rf_sel_q  <= 5'd0;
      rf_data_q <= '0;
    end else begin
      full_a_q  <= full_a_d;
      sel_a_q   <= sel_a_d;
      data_a_q  <= data_a_d;
      full_b_q  <= full_b_d;
      sel_b_q   <= sel_b_d;
      data_b_q  <= data_b_d;
      age_q     <= age_d;
      rr_q      <= rr_d;
      rf_ld_q   <= rf_ld_d;
      rf_sel_q  <= rf_sel_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Hazard scoreboard decoded purely from the buffer flops.
  always_comb begin
    Pending_Mask = 32'd0;
    if (full_a_q) Pending_Mask = Pending_Mask | (32'd1 << sel_a_q);
    if (full_b_q) Pending_Mask = Pending_Mask | (32'd1 << sel_b_q);
  end

  assign Busy      = full_a_q || full_b_q;
  assign RF_Ld     = rf_ld_q;
  assign RF_Select = rf_sel_q;
  assign RF_Data   = rf_data_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        A_Valid, B_Valid;
  logic [4:0]  A_Select, B_Select;
  logic [31:0] A_Data, B_Data;
  logic        A_Ready, B_Ready, RF_Ld, Busy;
  logic [4:0]  RF_Select;
  logic [31:0] RF_Data, Pending_Mask;
  logic        A_Ready0, B_Ready0, RF_Ld0, Busy0;
  logic [4:0]  RF_Select0;
  logic [31:0] RF_Data0, Pending_Mask0;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  rf_writeback_arbiter #(.DATA_W(32), .DROP_R0(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Select(A_Select), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Select(B_Select), .B_Data(B_Data),
    .RF_Ld(RF_Ld), .RF_Select(RF_Select), .RF_Data(RF_Data),
    .Pending_Mask(Pending_Mask), .Busy(Busy)
  );

  rf_writeback_arbiter #(.DATA_W(32), .DROP_R0(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Valid(A_Valid), .A_Ready(A_Ready0), .A_Select(A_Select), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready0), .B_Select(B_Select), .B_Data(B_Data),
    .RF_Ld(RF_Ld0), .RF_Select(RF_Select0), .RF_Data(RF_Data0),
    .Pending_Mask(Pending_Mask0), .Busy(Busy0)
  );

  typedef struct packed {
    logic        a_vld;
    logic [4:0]  a_sel;
    logic [31:0] a_dat;
    logic        b_vld;
    logic [4:0]  b_sel;
    logic [31:0] b_dat;
    logic        a_rdy;
    logic        b_rdy;
    logic        ld;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic [31:0] mask;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic av, input logic [4:0] as, input logic [31:0] ad,
                              input logic bv, input logic [4:0] bs, input logic [31:0] bd,
                              input logic ar, input logic br, input logic ld,
                              input logic [4:0] sel, input logic [31:0] dat, input logic [31:0] mask);
    vec_t v;
    v.a_vld = av; v.a_sel = as; v.a_dat = ad;
    v.b_vld = bv; v.b_sel = bs; v.b_dat = bd;
    v.a_rdy = ar; v.b_rdy = br; v.ld = ld;
    v.sel = sel; v.dat = dat; v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bs, input logic [31:0] bd);
    A_Valid = av; A_Select = as; A_Data = ad;
    B_Valid = bv; B_Select = bs; B_Data = bd;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] r9;
    logic [4:0]  psel;
    logic [31:0] pdat;
    logic [31:0] pmask;

    // ---------------- reset with A_Valid held high ----------------
    Reset_n = 1'b0;
    drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0);
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk);
    chk("rst_ld", {31'd0, RF_Ld}, 32'd0);
    chk("rst_mask", Pending_Mask, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("rst_a_rdy", {31'd0, A_Ready}, 32'd1);
    chk("rst_sel", {27'd0, RF_Select}, 32'd0);
    A_Valid = 1'b0;
    next_cycle();

    // ---------------- table of directed vectors ----------------
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 1, 0, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 0, 0, 32'h0,        32'h20));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 5, 32'hDEADBEEF, 32'h0));
    // contention, different registers, pointer at A
    vq.push_back(mk(1, 3, 32'h1,        1, 4, 32'h2, 1, 1, 0, 5, 32'hDEADBEEF, 32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 0, 0, 5, 32'hDEADBEEF, 32'h18));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 3, 32'h1,        32'h10));
    // second contention: B first
    vq.push_back(mk(1, 3, 32'h1,        1, 4, 32'h2, 1, 1, 1, 4, 32'h2,     32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  0, 1, 0, 4, 32'h2,        32'h18));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 4, 32'h2,        32'h08));
    // third contention: A first, pointer moves to B
    vq.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 1, 1, 3, 32'h1,    32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 0, 0, 3, 32'h1,        32'h6));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 1, 32'h11,       32'h4));
    // same register loaded on both sides together: A wins despite pointer at B
    vq.push_back(mk(1, 9, 32'hA,        1, 9, 32'hB, 1, 1, 1, 2, 32'h22,    32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 0, 0, 2, 32'h22,       32'h200));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 9, 32'hA,        32'h200));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 9, 32'hB,        32'h0));
    // pointer was not moved by the same-register grant: B first here
    vq.push_back(mk(1, 3, 32'h1,        1, 4, 32'h2, 1, 1, 0, 9, 32'hB,     32'h0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  0, 1, 0, 9, 32'hB,        32'h18));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 4, 32'h2,        32'h08));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1, 3, 32'h1,        32'h0));
    // back-to-back A stream R1..R8
    for (int k = 0; k < 8; k++) begin
      psel  = (k >= 2) ? 5'(k - 1) : 5'd3;
      pdat  = (k >= 2) ? 32'(32'h100 + k - 1) : 32'h1;
      pmask = (k == 0) ? 32'd0 : (32'd1 << k);
      vq.push_back(mk(1, 5'(k + 1), 32'(32'h100 + k + 1), 0, 0, 0,
                      1, 1, (k >= 2), psel, pdat, pmask));
    end
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h107, 32'h100));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 32'h108, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 8, 32'h108, 32'h0));

    foreach (vq[i]) begin
      drive(vq[i].a_vld, vq[i].a_sel, vq[i].a_dat, vq[i].b_vld, vq[i].b_sel, vq[i].b_dat);
      @(negedge Clk);
      chk($sformatf("v%0d_a_rdy", i), {31'd0, A_Ready}, {31'd0, vq[i].a_rdy});
      chk($sformatf("v%0d_b_rdy", i), {31'd0, B_Ready}, {31'd0, vq[i].b_rdy});
      chk($sformatf("v%0d_ld", i), {31'd0, RF_Ld}, {31'd0, vq[i].ld});
      chk($sformatf("v%0d_sel", i), {27'd0, RF_Select}, {27'd0, vq[i].sel});
      chk($sformatf("v%0d_dat", i), RF_Data, vq[i].dat);
      chk($sformatf("v%0d_mask", i), Pending_Mask, vq[i].mask);
      chk($sformatf("v%0d_busy", i), {31'd0, Busy}, {31'd0, (vq[i].mask != 32'd0)});
      next_cycle();
    end

    // ---------------- R0 drop ----------------
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    chk("r0_a_rdy0", {31'd0, A_Ready}, 32'd1);
    next_cycle();
    A_Valid = 1'b0;
    @(negedge Clk);
    chk("r0_mask", Pending_Mask, 32'h1);
    chk("r0_a_rdy1", {31'd0, A_Ready}, 32'd1);
    chk("r0_ld_e0", {31'd0, RF_Ld}, 32'd0);
    next_cycle();
    @(negedge Clk);
    chk("r0_ld_drop", {31'd0, RF_Ld}, 32'd0);
    chk("r0_mask_clr", Pending_Mask, 32'h0);
    chk("r0_ld_keep", {31'd0, RF_Ld0}, 32'd1);
    chk("r0_sel_keep", {27'd0, RF_Select0}, 32'd0);
    chk("r0_dat_keep", RF_Data0, 32'hFFFFFFFF);
    next_cycle();
    @(negedge Clk);
    chk("r0_ld_drop2", {31'd0, RF_Ld}, 32'd0);
    next_cycle();

    // ---------------- same register: B then A ----------------
    r9 = 32'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB);
    @(negedge Clk);
    chk("ord_b_rdy", {31'd0, B_Ready}, 32'd1);
    next_cycle();
    drive(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    chk("ord_mask_b", Pending_Mask, 32'h200);
    chk("ord_a_rdy", {31'd0, A_Ready}, 32'd1);
    next_cycle();
    A_Valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk($sformatf("ord_ld%0d", c), {31'd0, RF_Ld}, 32'd1);
      chk($sformatf("ord_sel%0d", c), {27'd0, RF_Select}, 32'd9);
      chk($sformatf("ord_dat%0d", c), RF_Data, (c == 0) ? 32'hB : 32'hA);
      if (RF_Ld && RF_Select == 5'd9) r9 = RF_Data;
      next_cycle();
    end
    chk("ord_final_r9", r9, 32'hA);

    // ---------------- async reset mid-burst ----------------
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    chk("arst_pre_ld", {31'd0, RF_Ld}, 32'd1);
    chk("arst_pre_busy", {31'd0, Busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("arst_ld", {31'd0, RF_Ld}, 32'd0);
    chk("arst_sel", {27'd0, RF_Select}, 32'd0);
    chk("arst_dat", RF_Data, 32'd0);
    chk("arst_mask", Pending_Mask, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk($sformatf("arst_post_ld%0d", c), {31'd0, RF_Ld}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
